// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg: shared widths, shift register mode codes and sequencer states
package shift_seq_ctrl_pkg;
    localparam int WIDTH = 4;
    localparam int CW    = 3;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
    // requests beyond the register width are treated as a full-width shift
    function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
        return (c > CW'(WIDTH)) ? CW'(WIDTH) : c;
    endfunction
endpackage

// File: rtl/shift_seq_cnt.sv
// shift_seq_cnt: loadable down-counter with enable and a "count is one" flag
module shift_seq_cnt
    import shift_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          one
);
    // load wins over decrement; counter idles otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= load ? val : en ? cnt - 1'b1 : cnt;
    assign one = (cnt == CW'(1));
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences load-then-shift jobs onto a 4-bit universal shift register
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [CW-1:0]    req_cnt,
    input  logic             stall,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_d,
    output logic             sr_oe,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    remain
);
    state_t           state, nxt;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic             accept;
    logic             last;
    assign accept = req_valid && (state == ST_IDLE);
    // the counter is armed at accept so REMAIN already shows the job size during LOAD
    shift_seq_cnt u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .val   (clamp_cnt(req_cnt)),
        .en    ((state == ST_SHIFT) && !stall),
        .cnt   (remain),
        .one   (last)
    );
    // state register plus job capture; sr_d keeps the last job's data until the next accept
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= ST_IDLE;
            data_q <= '0;
            dir_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                data_q <= req_data;
                dir_q  <= req_dir;
            end
        end
    // next state and mode select; stall only gates the shift of the current SHIFT cycle
    always_comb begin
        nxt  = state;
        sr_s = MODE_HOLD;
        nxt  = (state == ST_IDLE)  ? (accept ? ST_LOAD : ST_IDLE) :
               (state == ST_LOAD)  ? ((remain == '0) ? ST_DONE : ST_SHIFT) :
               (state == ST_SHIFT) ? ((!stall && last) ? ST_DONE : ST_SHIFT) :
                                     ST_IDLE;
        sr_s = (state == ST_LOAD)            ? MODE_LOAD :
               (state == ST_SHIFT && !stall) ? (dir_q ? MODE_SHL : MODE_SHR) :
                                               MODE_HOLD;
    end
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign sr_oe     = (state == ST_IDLE);
    assign sr_d      = data_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks of the sequencer driving a behavioural shift register
module tb_shift_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_data = '0;
    logic       req_dir = 1'b0;
    logic [2:0] req_cnt = '0;
    logic       stall = 1'b0;
    logic [1:0] sr_s;
    logic [3:0] sr_d;
    logic       sr_oe;
    logic       busy;
    logic       done;
    logic [2:0] remain;
    logic [3:0] q = '0;
    int         done_n = 0;
    int         total = 0;
    int         bad = 0;
    int         snap;

    shift_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_dir(req_dir), .req_cnt(req_cnt), .stall(stall),
        .sr_s(sr_s), .sr_d(sr_d), .sr_oe(sr_oe), .busy(busy), .done(done), .remain(remain)
    );

    always #5 clk = ~clk;

    // universal shift register: 00 hold, 01 right (0 in at MSB), 10 left (0 in at LSB), 11 load
    always_ff @(posedge clk)
        q <= (sr_s == 2'b11) ? sr_d : (sr_s == 2'b01) ? {1'b0, q[3:1]} :
             (sr_s == 2'b10) ? {q[2:0], 1'b0} : q;

    always_ff @(posedge clk) done_n <= done_n + int'(done);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s"}, 8'(sr_s), 8'h0);
        chk({tag, "_d"}, 8'(sr_d), 8'h0);
        chk({tag, "_oe"}, 8'(sr_oe), 8'h1);
        chk({tag, "_rdy"}, 8'(req_ready), 8'h1);
        chk({tag, "_busy"}, 8'(busy), 8'h0);
        chk({tag, "_done"}, 8'(done), 8'h0);
        chk({tag, "_rem"}, 8'(remain), 8'h0);
    endtask

    task automatic offer(input logic [3:0] d, input logic dir, input logic [2:0] c);
        req_valid = 1'b1; req_data = d; req_dir = dir; req_cnt = c;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        // 1: load 1010, one right shift
        offer(4'b1010, 1'b0, 3'd1);
        chk("t1_c1_s", 8'(sr_s), 8'h3);
        chk("t1_c1_d", 8'(sr_d), 8'hA);
        chk("t1_c1_oe", 8'(sr_oe), 8'h0);
        chk("t1_c1_rdy", 8'(req_ready), 8'h0);
        chk("t1_c1_busy", 8'(busy), 8'h1);
        tick();
        chk("t1_c2_s", 8'(sr_s), 8'h1);
        chk("t1_c2_rem", 8'(remain), 8'h1);
        chk("t1_c2_done", 8'(done), 8'h0);
        tick();
        chk("t1_c3_s", 8'(sr_s), 8'h0);
        chk("t1_c3_done", 8'(done), 8'h1);
        chk("t1_c3_q", 8'(q), 8'h5);
        tick();
        chk("t1_idle_done", 8'(done), 8'h0);
        chk("t1_idle_rdy", 8'(req_ready), 8'h1);
        // 2: left by two, stalled on the first shift cycle
        offer(4'b1010, 1'b1, 3'd2);
        chk("t2_c1_s", 8'(sr_s), 8'h3);
        tick();
        stall = 1'b1;
        #1;
        chk("t2_c2_s", 8'(sr_s), 8'h0);
        chk("t2_c2_rem", 8'(remain), 8'h2);
        tick();
        stall = 1'b0;
        #1;
        chk("t2_c3_s", 8'(sr_s), 8'h2);
        chk("t2_c3_rem", 8'(remain), 8'h2);
        tick();
        chk("t2_c4_s", 8'(sr_s), 8'h2);
        chk("t2_c4_rem", 8'(remain), 8'h1);
        chk("t2_c4_done", 8'(done), 8'h0);
        tick();
        chk("t2_c5_s", 8'(sr_s), 8'h0);
        chk("t2_c5_done", 8'(done), 8'h1);
        chk("t2_c5_q", 8'(q), 8'h8);
        tick();
        // 3: zero shifts
        offer(4'b1110, 1'b0, 3'd0);
        chk("t3_c1_s", 8'(sr_s), 8'h3);
        tick();
        chk("t3_c2_s", 8'(sr_s), 8'h0);
        chk("t3_c2_done", 8'(done), 8'h1);
        chk("t3_c2_q", 8'(q), 8'hE);
        chk("t3_c2_oe", 8'(sr_oe), 8'h0);
        tick();
        chk("t3_idle_oe", 8'(sr_oe), 8'h1);
        chk("t3_idle_d", 8'(sr_d), 8'hE);
        // 4: count 7 clamps to 4
        offer(4'b1011, 1'b0, 3'd7);
        chk("t4_c1_rem", 8'(remain), 8'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4_c%0d_s", i + 2), 8'(sr_s), 8'h1);
            chk($sformatf("t4_c%0d_rem", i + 2), 8'(remain), 8'(4 - i));
        end
        tick();
        chk("t4_c6_done", 8'(done), 8'h1);
        chk("t4_c6_q", 8'(q), 8'h0);
        tick();
        // 5: reset during SHIFT with two shifts left
        offer(4'b1100, 1'b1, 3'd4);
        tick();
        tick();
        tick();
        chk("t5_pre_rem", 8'(remain), 8'h2);
        snap = done_n;
        rst_n = 1'b0;
        #1;
        chk_reset("t5_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_no_done", 8'(done_n - snap), 8'h0);
        offer(4'b0110, 1'b1, 3'd1);
        chk("t5_c1_s", 8'(sr_s), 8'h3);
        tick();
        chk("t5_c2_s", 8'(sr_s), 8'h2);
        tick();
        chk("t5_c3_done", 8'(done), 8'h1);
        chk("t5_c3_q", 8'(q), 8'hC);
        tick();
        // 6: valid held high across two jobs
        snap = done_n;
        req_valid = 1'b1; req_data = 4'b0011; req_dir = 1'b0; req_cnt = 3'd1;
        tick();
        req_data = 4'b0101; req_dir = 1'b1; req_cnt = 3'd2;
        chk("t6_a_c1_d", 8'(sr_d), 8'h3);
        tick();
        chk("t6_a_c2_d", 8'(sr_d), 8'h3);
        chk("t6_a_c2_s", 8'(sr_s), 8'h1);
        tick();
        chk("t6_a_c3_done", 8'(done), 8'h1);
        chk("t6_a_c3_rdy", 8'(req_ready), 8'h0);
        tick();
        chk("t6_idle_rdy", 8'(req_ready), 8'h1);
        chk("t6_a_q", 8'(q), 8'h1);
        tick();
        req_valid = 1'b0;
        chk("t6_b_c1_s", 8'(sr_s), 8'h3);
        chk("t6_b_c1_d", 8'(sr_d), 8'h5);
        chk("t6_b_c1_rem", 8'(remain), 8'h2);
        tick();
        chk("t6_b_c2_s", 8'(sr_s), 8'h2);
        tick();
        chk("t6_b_c3_s", 8'(sr_s), 8'h2);
        tick();
        chk("t6_b_c4_done", 8'(done), 8'h1);
        chk("t6_b_q", 8'(q), 8'h4);
        tick();
        tick();
        chk("t6_done_count", 8'(done_n - snap), 8'h2);
        chk("t6_final_busy", 8'(busy), 8'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
